mmio_io_controller: RTL and testbench

- Parametrised memory-mapped board-I/O peripheral on the shared processor bus: tri-state data, address, read and write strobes.
- Replaces the direct wiring of LEDs to bus data bits with addressable registers for LEDs, 7-segment displays, switches and buttons.
- Adds synchronisation, debouncing, sticky button-press capture and hex-to-segment decoding.
- Sits beside the GPU as a bus slave in the DE0 top level.

---
 rtl/io_pkg.sv | 31 +++
 rtl/io_debounce.sv | 57 +++++
 rtl/mmio_io_controller.sv | 127 ++++++++++++
 tb/tb_mmio_io_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the board I/O block.
// Register indices, hex glyph table, blank pattern.
package io_pkg;

  localparam logic [2:0] REG_LED         = 3'd0;
  localparam logic [2:0] REG_HEX_VALUE   = 3'd1;
  localparam logic [2:0] REG_HEX_BLANK   = 3'd2;
  localparam logic [2:0] REG_SWITCH      = 3'd3;
  localparam logic [2:0] REG_BUTTON      = 3'd4;
  localparam logic [2:0] REG_BUTTON_EDGE = 3'd5;
  localparam logic [2:0] REG_ID          = 3'd6;
  localparam logic [2:0] REG_RSVD        = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low g..a glyphs for 0-F.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_seg(
    input logic [3:0] val,
    input logic       blank
  );
    return blank ? SEG_BLANK : HEX_GLYPH[val];
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Synchroniser + per-bit debouncer.
// Ports: clock, reset, pin (raw), stable (debounced).
module io_debounce #(
  parameter int   WIDTH           = 1,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VALUE     = 1'b0,
  parameter logic INVERT          = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] raw;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= {WIDTH{RESET_VALUE}};
      sync2 <= {WIDTH{RESET_VALUE}};
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Polarity fix happens after the synchroniser so the
  // flops still reset to the idle pin level.
  assign raw = INVERT ? ~sync2 : sync2;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          st;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (raw[i] == st) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        st  <= raw[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stable[i] = st;
  end

endmodule

// File: rtl/mmio_io_controller.sv
// Memory-mapped LED/7-seg/switch/button peripheral.
// Ports: reset, clock, data(inout), address, read, write, switch, button_n, led, hex.
module mmio_io_controller
  import io_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    ADDR_WIDTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 64'h0000_0000_0000_1000,
  parameter int                    NUM_LEDS        = 10,
  parameter int                    NUM_SWITCHES    = 10,
  parameter int                    NUM_BUTTONS     = 3,
  parameter int                    NUM_HEX         = 4,
  parameter int                    DEBOUNCE_CYCLES = 50000
) (
  input  logic                    reset,
  input  logic                    clock,
  inout  tri   [DATA_WIDTH-1:0]   data,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [NUM_SWITCHES-1:0] switch,
  input  logic [NUM_BUTTONS-1:0]  button_n,
  output logic [NUM_LEDS-1:0]     led,
  output logic [7*NUM_HEX-1:0]    hex
);

  if (NUM_LEDS > DATA_WIDTH || NUM_SWITCHES > DATA_WIDTH ||
      NUM_BUTTONS > DATA_WIDTH || 4 * NUM_HEX > DATA_WIDTH ||
      DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("mmio_io_controller: illegal parameter set");
  end

  localparam logic [31:0] ID_VALUE = {
    8'(NUM_HEX), 8'(NUM_BUTTONS), 8'(NUM_SWITCHES), 8'(NUM_LEDS)
  };

  logic [ADDR_WIDTH-1:0]   off;
  logic                    hit;
  logic [2:0]              idx;
  logic                    wr_hit;
  logic [4*NUM_HEX-1:0]    hex_value;
  logic [NUM_HEX-1:0]      hex_blank;
  logic [NUM_SWITCHES-1:0] sw_db;
  logic [NUM_BUTTONS-1:0]  btn_db;
  logic [NUM_BUTTONS-1:0]  btn_q;
  logic [NUM_BUTTONS-1:0]  btn_edge;
  logic [NUM_BUTTONS-1:0]  edge_clr;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    unused_data;

  // Unsigned offset: below-base addresses wrap high and miss.
  assign off    = address - BASE_ADDR;
  assign hit    = (off[ADDR_WIDTH-1:3] == '0);
  assign idx    = off[2:0];
  assign wr_hit = write && hit;

  assign unused_data = ^data;

  io_debounce #(
    .WIDTH(NUM_SWITCHES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE(1'b0),
    .INVERT(1'b0)
  ) u_sw_db (
    .clock(clock),
    .reset(reset),
    .pin(switch),
    .stable(sw_db)
  );

  io_debounce #(
    .WIDTH(NUM_BUTTONS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE(1'b1),
    .INVERT(1'b1)
  ) u_btn_db (
    .clock(clock),
    .reset(reset),
    .pin(button_n),
    .stable(btn_db)
  );

  assign edge_clr = (wr_hit && idx == REG_BUTTON_EDGE)
                  ? data[NUM_BUTTONS-1:0] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led       <= '0;
      hex_value <= '0;
      hex_blank <= '1;
      btn_q     <= '0;
      btn_edge  <= '0;
    end else begin
      if (wr_hit && idx == REG_LED)
        led <= data[NUM_LEDS-1:0];
      if (wr_hit && idx == REG_HEX_VALUE)
        hex_value <= data[4*NUM_HEX-1:0];
      if (wr_hit && idx == REG_HEX_BLANK)
        hex_blank <= data[NUM_HEX-1:0];
      btn_q <= btn_db;
      // New press beats a same-cycle clear.
      btn_edge <= (btn_edge & ~edge_clr) | (btn_db & ~btn_q);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_LED:         rdata[NUM_LEDS-1:0]     = led;
      REG_HEX_VALUE:   rdata[4*NUM_HEX-1:0]    = hex_value;
      REG_HEX_BLANK:   rdata[NUM_HEX-1:0]      = hex_blank;
      REG_SWITCH:      rdata[NUM_SWITCHES-1:0] = sw_db;
      REG_BUTTON:      rdata[NUM_BUTTONS-1:0]  = btn_db;
      REG_BUTTON_EDGE: rdata[NUM_BUTTONS-1:0]  = btn_edge;
      REG_ID:          rdata = DATA_WIDTH'(ID_VALUE);
      REG_RSVD:        rdata = '0;
      default:         rdata = '0;
    endcase
  end

  assign data = (read && hit && !write) ? rdata : 'z;

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    assign hex[7*i +: 7] = hex_seg(hex_value[4*i +: 4], hex_blank[i]);
  end

endmodule

// File: tb/tb_mmio_io_controller.sv
// Randomised self-checking bench for mmio_io_controller.
// Reference model tracks registers, debounce windows and press capture.
module tb_mmio_io_controller;

  localparam int DC = 4;
  localparam logic [63:0] BASE = 64'h1000;
  localparam logic [63:0] ID_EXP = 64'h0403_0A0A;
  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clock = 1'b0;
  logic        reset;
  tri   [63:0] data;
  logic [63:0] address;
  logic        read;
  logic        write;
  logic [9:0]  sw;
  logic [2:0]  button_n;
  logic [9:0]  led;
  logic [27:0] hex;
  logic        tb_drive;
  logic [63:0] tb_data;

  assign data = tb_drive ? tb_data : 'z;

  for (genvar i = 0; i < 64; i++) begin : g_pu
    pullup (data[i]);
  end

  always #5 clock = ~clock;

  mmio_io_controller #(
    .DEBOUNCE_CYCLES(DC),
    .BASE_ADDR(BASE)
  ) dut (
    .reset(reset),
    .clock(clock),
    .data(data),
    .address(address),
    .read(read),
    .write(write),
    .switch(sw),
    .button_n(button_n),
    .led(led),
    .hex(hex)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [9:0]  led_m;
  logic [15:0] hv_m;
  logic [3:0]  hb_m;
  logic [9:0]  sw_m;
  logic [9:0]  bt_m;
  logic [9:0]  bt_prev_m;
  logic [2:0]  edge_m;
  logic [9:0]  sw_hist[$];
  logic [9:0]  bt_hist[$];

  task automatic model_reset();
    led_m = '0; hv_m = '0; hb_m = 4'hF;
    sw_m = '0; bt_m = '0; bt_prev_m = '0; edge_m = '0;
    sw_hist.delete(); bt_hist.delete();
    for (int k = 0; k < DC + 2; k++) begin
      sw_hist.push_back('0);
      bt_hist.push_back('0);
    end
  endtask

  // A bit flips once the level seen through the two-flop
  // delay has disagreed with it for DC edges in a row.
  function automatic logic [9:0] deb(input logic [9:0] h[$],
                                     input logic [9:0] st);
    logic [9:0] n;
    n = st;
    for (int b = 0; b < 10; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int k = 0; k < DC; k++)
        if (h[h.size() - 2 - k][b] == st[b]) all_diff = 1'b0;
      if (all_diff) n[b] = ~st[b];
    end
    return n;
  endfunction

  function automatic logic [63:0] rd_model(input logic [2:0] i);
    case (i)
      3'd0: return 64'(led_m);
      3'd1: return 64'(hv_m);
      3'd2: return 64'(hb_m);
      3'd3: return 64'(sw_m);
      3'd4: return 64'(bt_m);
      3'd5: return 64'(edge_m);
      3'd6: return ID_EXP;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [27:0] hex_model();
    logic [27:0] h;
    for (int i = 0; i < 4; i++)
      h[7*i +: 7] = hb_m[i] ? 7'h7F : GLY[hv_m[4*i +: 4]];
    return h;
  endfunction

  task automatic model_edge();
    logic [63:0] off;
    logic [2:0]  press;
    logic [2:0]  clr;
    off   = address - BASE;
    press = bt_m[2:0] & ~bt_prev_m[2:0];
    bt_prev_m = bt_m;
    clr = '0;
    if (write && off < 64'd8) begin
      case (off[2:0])
        3'd0: led_m = tb_data[9:0];
        3'd1: hv_m  = tb_data[15:0];
        3'd2: hb_m  = tb_data[3:0];
        3'd5: clr   = tb_data[2:0];
        default: ;
      endcase
    end
    edge_m = (edge_m & ~clr) | press;
    sw_m = deb(sw_hist, sw_m);
    bt_m = deb(bt_hist, bt_m);
    sw_hist.push_back(sw);
    bt_hist.push_back({7'd0, ~button_n});
    void'(sw_hist.pop_front());
    void'(bt_hist.pop_front());
  endtask

  // ---------------- drivers ----------------
  task automatic bus(input bit r, input bit w, input logic [63:0] a,
                     input logic [63:0] d);
    read = r; write = w; address = a; tb_drive = w; tb_data = d;
  endtask

  task automatic step(input string tag, input bit ex,
                      input logic [63:0] ev);
    logic [63:0] off;
    off = address - BASE;
    #1;
    if (read && !write && off < 64'd8)
      chk({tag, "_rd"}, data, rd_model(off[2:0]));
    else
      chk({tag, "_bus"}, data, tb_drive ? tb_data : '1);
    if (ex) chk(tag, data, ev);
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    chk({tag, "_led"}, 64'(led), 64'(led_m));
    chk({tag, "_hex"}, 64'(hex), 64'(hex_model()));
  endtask

  initial begin
    reset = 1'b1;
    sw = '0;
    button_n = 3'b111;
    bus(0, 0, 64'h0, 64'h0);
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_led", 64'(led), 64'h0);
    chk("rst_hex", 64'(hex), 64'hFFF_FFFF);
    reset = 1'b0;

    bus(1, 0, BASE + 0, 0); step("rst_r0", 1, 64'h0);
    bus(1, 0, BASE + 2, 0); step("rst_r2", 1, 64'hF);
    bus(1, 0, BASE + 6, 0); step("rst_id", 1, ID_EXP);
    bus(0, 0, BASE, 0);     step("idle_z", 1, '1);

    bus(0, 1, BASE + 1, 64'h2A5F); step("wr_hv", 0, 0);
    bus(0, 1, BASE + 2, 64'h0);    step("wr_hb", 0, 0);
    chk("dig0_F", 64'(hex[6:0]), 64'h0E);
    chk("dig3_2", 64'(hex[27:21]), 64'h24);
    bus(0, 1, BASE + 2, 64'h2);    step("wr_hb2", 0, 0);
    chk("dig1_blank", 64'(hex[13:7]), 64'h7F);

    sw = 10'h155;
    bus(1, 0, BASE + 3, 0);
    for (int k = 1; k <= 8; k++)
      step("sw_db", 1, (k >= 7) ? 64'h155 : 64'h0);
    sw = 10'h154;
    for (int k = 0; k < 3; k++) step("sw_gl", 1, 64'h155);
    sw = 10'h155;
    for (int k = 0; k < 6; k++) step("sw_gl", 1, 64'h155);

    button_n = 3'b101;
    bus(1, 0, BASE + 4, 0);
    for (int k = 1; k <= 6; k++) step("btn", 1, 64'h0);
    button_n = 3'b111;
    for (int k = 7; k <= 13; k++)
      step("btn", 1, (k >= 13) ? 64'h0 : 64'h2);
    bus(1, 0, BASE + 5, 0); step("edge1", 1, 64'h2);

    button_n = 3'b110;
    bus(0, 0, BASE, 0);
    for (int k = 1; k <= 6; k++) step("btn0", 0, 0);
    bus(0, 1, BASE + 5, 64'h3); step("w1c_set", 0, 0);
    bus(1, 0, BASE + 5, 0);     step("setwin", 1, 64'h1);
    bus(0, 1, BASE + 5, 64'h2); step("w1c_b1", 0, 0);
    bus(1, 0, BASE + 5, 0);     step("edge_keep", 1, 64'h1);
    button_n = 3'b111;
    bus(0, 1, BASE + 5, 64'h1); step("w1c_b0", 0, 0);
    bus(1, 0, BASE + 5, 0);     step("edge_clr", 1, 64'h0);

    bus(0, 1, BASE, 64'h3FF); step("led_on", 0, 0);
    chk("led_3ff", 64'(led), 64'h3FF);
    bus(0, 0, BASE, 0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_led", 64'(led), 64'h0);
    chk("async_hex", 64'(hex), 64'hFFF_FFFF);
    bus(1, 0, BASE + 2, 0); step("rst_rd", 1, 64'hF);
    reset = 1'b0;
    bus(0, 0, BASE, 0);     step("post_rst", 1, '1);

    bus(1, 1, BASE, 64'h0AA); step("rw", 1, 64'h0AA);
    chk("rw_led", 64'(led), 64'h0AA);

    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  op;
      logic [63:0] a;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = $urandom_range(0, 1) ? BASE + 8 + 64'($urandom_range(0, 15))
                                 : BASE - 1 - 64'($urandom_range(0, 15));
      else
        a = BASE + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) sw = 10'($urandom);
      if ($urandom_range(0, 4) == 0)
        button_n = button_n ^ (3'b001 << $urandom_range(0, 2));
      bus(op[0], op[1], a, {$urandom, $urandom});
      step("rnd", 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
